// File: rtl/instr_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl_if
//   Bus bundle between the fetch controller and the instruction memory and
//   redirect logic.
//
//   imem_addr   word address into the synchronous instruction memory
//   imem_rdata  read data, valid one cycle after the address
//   pc_load     redirect request (taken only during EXEC)
//   pc_target   redirect address
//
//   master : fetch-controller side
//   slave  : memory / datapath side
// ---------------------------------------------------------------------------
interface instr_fetch_ctrl_if #(
    parameter int AW = 16
);
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          pc_load;
    logic [AW-1:0] pc_target;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  pc_load,
        input  pc_target
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output pc_load,
        output pc_target
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//   Instruction fetch / sequencing controller. Walks a small FSM
//   (HLT -> FETCH0 -> FETCH1 [-> FETCH2] -> EXEC) that reads one- or two-word
//   instructions from a synchronous instruction memory, owns the PC, accepts
//   a PC redirect in EXEC and stops on the END opcode.
//
//   clk            rising-edge clock
//   reset          synchronous active-high reset, beats every other input
//   start          pulse that leaves HLT
//   bus            imem address/data and pc_load/pc_target (master side)
//   instr0         first instruction word (opcode in [31:24])
//   instr1         second word, 0 for one-word instructions
//   current_state  FSM state, used by the datapath to gate writes in EXEC
//   pc             program counter
//   halted         high while in HLT
//   retired        number of completed EXEC cycles (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int            AW        = 16,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [7:0]    OP_LBSET  = 8'h01,
    parameter logic [7:0]    OP_LIMM32 = 8'h20,
    parameter logic [7:0]    OP_END    = 8'hF0,
    parameter logic [3:0]    ST_HLT    = 4'd0,
    parameter logic [3:0]    ST_FETCH0 = 4'd1,
    parameter logic [3:0]    ST_FETCH1 = 4'd2,
    parameter logic [3:0]    ST_FETCH2 = 4'd3,
    parameter logic [3:0]    ST_EXEC   = 4'd4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instr_fetch_ctrl_if.master   bus,
    output logic [31:0]          instr0,
    output logic [31:0]          instr1,
    output logic [3:0]           current_state,
    output logic [AW-1:0]        pc,
    output logic                 halted,
    output logic [31:0]          retired
);

    logic [3:0]    state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [31:0]   instr0_nxt;
    logic [31:0]   instr1_nxt;
    logic [31:0]   retired_nxt;
    logic [7:0]    rd_op;
    logic          rd_two_word;
    logic          is_end;

    // Memory address is the PC register itself; no combinational lookahead.
    assign bus.imem_addr = pc;

    assign rd_op       = bus.imem_rdata[31:24];
    assign rd_two_word = (rd_op == OP_LBSET) || (rd_op == OP_LIMM32);
    assign is_end      = (instr0[31:24] == OP_END);

    always_comb begin
        state_nxt   = current_state;
        pc_nxt      = pc;
        instr0_nxt  = instr0;
        instr1_nxt  = instr1;
        retired_nxt = retired;

        case (current_state)
            ST_HLT: begin
                if (start)
                    state_nxt = ST_FETCH0;
            end
            ST_FETCH0: begin
                // Address pc is on the bus this cycle; data arrives in FETCH1.
                pc_nxt    = pc + AW'(1);
                state_nxt = ST_FETCH1;
            end
            ST_FETCH1: begin
                instr0_nxt = bus.imem_rdata;
                if (rd_two_word) begin
                    // The already-incremented pc addresses the second word;
                    // it wraps naturally at 2^AW.
                    pc_nxt    = pc + AW'(1);
                    state_nxt = ST_FETCH2;
                end else begin
                    instr1_nxt = '0;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_FETCH2: begin
                instr1_nxt = bus.imem_rdata;
                state_nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                retired_nxt = retired + 32'd1;
                // Redirect and END are independent: both can take effect.
                if (bus.pc_load)
                    pc_nxt = bus.pc_target;
                state_nxt = is_end ? ST_HLT : ST_FETCH0;
            end
            default: begin
                state_nxt = ST_HLT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= ST_HLT;
            pc            <= RESET_PC;
            instr0        <= '0;
            instr1        <= '0;
            retired       <= '0;
            halted        <= 1'b1;
        end else begin
            current_state <= state_nxt;
            pc            <= pc_nxt;
            instr0        <= instr0_nxt;
            instr1        <= instr1_nxt;
            retired       <= retired_nxt;
            // Registered copy of "next state is HLT" so halted lines up with
            // current_state without a decode on the output.
            halted        <= (state_nxt == ST_HLT);
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
//   Directed bench for instr_fetch_ctrl. dut_a uses RESET_PC=0, dut_b uses
//   RESET_PC=16'hFFFF for the address-wrap case. Both share one behavioural
//   synchronous instruction memory image and the reset line.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;

    logic [31:0]   instr0_a, instr1_a, retired_a;
    logic [3:0]    state_a;
    logic [AW-1:0] pc_a;
    logic          halted_a;

    logic [31:0]   instr0_b, instr1_b, retired_b;
    logic [3:0]    state_b;
    logic [AW-1:0] pc_b;
    logic          halted_b;

    logic [31:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_ctrl_if #(.AW(AW)) bus_a ();
    instr_fetch_ctrl_if #(.AW(AW)) bus_b ();

    always #5 clk = ~clk;

    // Synchronous instruction memories: data valid one cycle after address.
    always @(posedge clk) bus_a.imem_rdata <= mem[bus_a.imem_addr];
    always @(posedge clk) bus_b.imem_rdata <= mem[bus_b.imem_addr];

    instr_fetch_ctrl #(.AW(AW), .RESET_PC(16'h0000)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (start_a),
        .bus           (bus_a),
        .instr0        (instr0_a),
        .instr1        (instr1_a),
        .current_state (state_a),
        .pc            (pc_a),
        .halted        (halted_a),
        .retired       (retired_a)
    );

    instr_fetch_ctrl #(.AW(AW), .RESET_PC(16'hFFFF)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (start_b),
        .bus           (bus_b),
        .instr0        (instr0_b),
        .instr1        (instr1_b),
        .current_state (state_b),
        .pc            (pc_b),
        .halted        (halted_b),
        .retired       (retired_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 unit after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        start_a         = 1'b0;
        start_b         = 1'b0;
        bus_a.pc_load   = 1'b0;
        bus_a.pc_target = '0;
        bus_b.pc_load   = 1'b0;
        bus_b.pc_target = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;

        // ---- one-word sequence ----
        mem[0] = 32'h02040005;
        mem[1] = 32'hF0000000;
        do_reset();
        chk("rst_state",   {28'h0, state_a}, 32'd0);
        chk("rst_pc",      {16'h0, pc_a}, 32'd0);
        chk("rst_addr",    {16'h0, bus_a.imem_addr}, 32'd0);
        chk("rst_instr0",  instr0_a, 32'h0);
        chk("rst_instr1",  instr1_a, 32'h0);
        chk("rst_retired", retired_a, 32'h0);
        chk("rst_halted",  {31'h0, halted_a}, 32'd1);
        chk("rst_pc_b",    {16'h0, pc_b}, 32'h0000FFFF);
        start_a = 1'b1;
        step(); start_a = 1'b0;
        chk("w1_st_f0",  {28'h0, state_a}, 32'd1);
        chk("w1_halted", {31'h0, halted_a}, 32'd0);
        step();
        chk("w1_st_f1",  {28'h0, state_a}, 32'd2);
        step();
        chk("w1_st_ex",  {28'h0, state_a}, 32'd4);
        chk("w1_instr0", instr0_a, 32'h02040005);
        chk("w1_instr1", instr1_a, 32'h0);
        chk("w1_pc_ex",  {16'h0, pc_a}, 32'd1);
        step();
        chk("w1_st_f0b", {28'h0, state_a}, 32'd1);
        chk("w1_ret1",   retired_a, 32'd1);
        step();
        chk("w1_st_f1b", {28'h0, state_a}, 32'd2);
        step();
        chk("w1_st_exb", {28'h0, state_a}, 32'd4);
        chk("w1_end",    instr0_a, 32'hF0000000);
        step();
        chk("w1_st_hlt", {28'h0, state_a}, 32'd0);
        chk("w1_halted_end", {31'h0, halted_a}, 32'd1);
        chk("w1_pc_hlt", {16'h0, pc_a}, 32'd2);
        chk("w1_retired", retired_a, 32'd2);
        step(); step();
        chk("w1_hold_st",     {28'h0, state_a}, 32'd0);
        chk("w1_hold_instr0", instr0_a, 32'hF0000000);
        chk("w1_hold_ret",    retired_a, 32'd2);

        // ---- two-word LIMM32 ----
        mem[0] = 32'h20080000;
        mem[1] = 32'hDEADBEEF;
        mem[2] = 32'hF0000000;
        do_reset();
        start_a = 1'b1;
        step(); start_a = 1'b0;
        step();
        step();
        chk("l32_st_f2", {28'h0, state_a}, 32'd3);
        chk("l32_pc_f2", {16'h0, pc_a}, 32'd2);
        step();
        chk("l32_st_ex", {28'h0, state_a}, 32'd4);
        chk("l32_instr0", instr0_a, 32'h20080000);
        chk("l32_instr1", instr1_a, 32'hDEADBEEF);
        step(); step(); step();
        chk("l32_end_i1", instr1_a, 32'h0);
        step();
        chk("l32_st_hlt", {28'h0, state_a}, 32'd0);
        chk("l32_pc_hlt", {16'h0, pc_a}, 32'd3);
        chk("l32_retired", retired_a, 32'd2);

        // ---- redirect ----
        mem[0]     = 32'h02040005;
        mem[1]     = 32'h02000000;
        mem[2]     = 32'h02000000;
        mem[16'h10] = 32'hF0000000;
        do_reset();
        start_a = 1'b1;
        step(); start_a = 1'b0;
        step();
        step();
        chk("rd_st_ex", {28'h0, state_a}, 32'd4);
        bus_a.pc_load   = 1'b1;
        bus_a.pc_target = 16'h0010;
        step();
        bus_a.pc_load = 1'b0;
        chk("rd_st_f0", {28'h0, state_a}, 32'd1);
        chk("rd_addr",  {16'h0, bus_a.imem_addr}, 32'h10);
        step(); step();
        chk("rd_end", instr0_a, 32'hF0000000);
        step();
        chk("rd_st_hlt", {28'h0, state_a}, 32'd0);
        chk("rd_pc_hlt", {16'h0, pc_a}, 32'h11);
        chk("rd_retired", retired_a, 32'd2);

        // ---- PC wrap on dut_b (RESET_PC = 0xFFFF) ----
        mem[16'hFFFF] = 32'h20000000;
        mem[0]        = 32'h12345678;
        mem[1]        = 32'hF0000000;
        do_reset();
        start_b = 1'b1;
        step(); start_b = 1'b0;
        chk("wr_addr_f0", {16'h0, bus_b.imem_addr}, 32'h0000FFFF);
        step();
        chk("wr_pc_f1", {16'h0, pc_b}, 32'd0);
        step();
        chk("wr_st_f2", {28'h0, state_b}, 32'd3);
        step();
        chk("wr_st_ex", {28'h0, state_b}, 32'd4);
        chk("wr_instr0", instr0_b, 32'h20000000);
        chk("wr_instr1", instr1_b, 32'h12345678);
        step(); step(); step(); step();
        chk("wr_st_hlt", {28'h0, state_b}, 32'd0);
        chk("wr_pc_hlt", {16'h0, pc_b}, 32'd2);
        chk("wr_retired", retired_b, 32'd2);

        // ---- reset mid-fetch and ignored inputs ----
        mem[0] = 32'h01000000;
        mem[1] = 32'hAAAA5555;
        mem[2] = 32'hF0000000;
        do_reset();
        start_a = 1'b1;
        step(); start_a = 1'b0;
        start_a = 1'b1;                 // start while running: no effect
        step(); start_a = 1'b0;
        chk("ig_start_st", {28'h0, state_a}, 32'd2);
        chk("ig_start_pc", {16'h0, pc_a}, 32'd1);
        bus_a.pc_load   = 1'b1;         // pc_load in FETCH1: no effect
        bus_a.pc_target = 16'h0030;
        step();
        bus_a.pc_load = 1'b0;
        chk("ig_load_st", {28'h0, state_a}, 32'd3);
        chk("ig_load_pc", {16'h0, pc_a}, 32'd2);
        chk("ig_instr0",  instr0_a, 32'h01000000);
        reset   = 1'b1;
        start_a = 1'b1;
        step();
        chk("mr_state",   {28'h0, state_a}, 32'd0);
        chk("mr_pc",      {16'h0, pc_a}, 32'd0);
        chk("mr_instr0",  instr0_a, 32'h0);
        chk("mr_instr1",  instr1_a, 32'h0);
        chk("mr_retired", retired_a, 32'h0);
        chk("mr_halted",  {31'h0, halted_a}, 32'd1);
        step();
        chk("mr_start_st", {28'h0, state_a}, 32'd0);
        reset   = 1'b0;
        start_a = 1'b0;
        step();
        chk("mr_stay_hlt", {28'h0, state_a}, 32'd0);

        // ---- pc_load together with END: loads and still halts ----
        mem[0] = 32'hF0000000;
        do_reset();
        start_a = 1'b1;
        step(); start_a = 1'b0;
        step(); step();
        chk("le_st_ex", {28'h0, state_a}, 32'd4);
        bus_a.pc_load   = 1'b1;
        bus_a.pc_target = 16'h0040;
        step();
        bus_a.pc_load = 1'b0;
        chk("le_st_hlt",  {28'h0, state_a}, 32'd0);
        chk("le_pc",      {16'h0, pc_a}, 32'h40);
        chk("le_retired", retired_a, 32'd1);
        chk("le_halted",  {31'h0, halted_a}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch and sequencing controller for the OSECPU core. It sits directly upstream of the execute-stage datapath. It reads 32-bit words from a synchronous instruction memory and assembles one- or two-word instructions into `instr0`/`instr1`. It also drives the 4-bit `current_state` that the datapath uses to gate register-file and label-table writes, which happen only in EXEC. It owns the program counter, accepts a PC-load request during EXEC, and stops on the END opcode.

## Interface
- `AW`, 16: instruction-memory word-address width.
- `RESET_PC`, 0: PC value after reset.
- `OP_LBSET`, 8'h01: opcode whose instruction carries a second word (base/count).
- `OP_LIMM32`, 8'h20: opcode whose instruction carries a second word (imm32).
- `OP_END`, 8'hF0: opcode that halts the sequencer after its EXEC cycle.
- `ST_HLT`/`ST_FETCH0`/`ST_FETCH1`/`ST_FETCH2`/`ST_EXEC`, 0/1/2/3/4: `current_state` encodings. The integration sets them to the shared definition-header values.
- `clk`  in  1  single clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; has priority over every other input.
- `start`  in  1  single-cycle pulse that leaves HLT; ignored in any other state.
- `imem_addr`  out  AW  word address to instruction memory; combinationally equal to `pc`.
- `imem_rdata`  in  32  read data; valid exactly one cycle after the address was presented.
- `pc_load`  in  1  request to redirect the PC; sampled only in ST_EXEC.
- `pc_target`  in  AW  redirect address, used when `pc_load` is accepted.
- `instr0`  out  32  first instruction word (opcode in [31:24]).
- `instr1`  out  32  second word; 0 for one-word instructions.
- `current_state`  out  4  FSM state, consumed by the datapath.
- `pc`  out  AW  program counter.
- `halted`  out  1  high while in ST_HLT.
- `retired`  out  32  count of EXEC cycles completed; wraps at 2^32.

## Operation
- Reset values:
  - `current_state`=ST_HLT, `pc`=RESET_PC, `instr0`=0, `instr1`=0, `retired`=0, `halted`=1.
  - `imem_addr` follows `pc`.
- ST_HLT: holds everything. `start`=1 → ST_FETCH0 with the current `pc`. The PC is not reset on restart.
- ST_FETCH0:
  - Memory address = `pc`.
  - At the edge: `pc`<=`pc`+1, → ST_FETCH1.
- ST_FETCH1:
  - `imem_rdata` is the first word. At the edge: `instr0`<=`imem_rdata`.
  - If `imem_rdata[31:24]` is OP_LBSET or OP_LIMM32: `pc`<=`pc`+1, → ST_FETCH2. The address presented in this cycle (the incremented `pc`) is the second word.
  - Otherwise: `instr1`<=0, → ST_EXEC.
- ST_FETCH2: `instr1`<=`imem_rdata`, → ST_EXEC.
- ST_EXEC:
  - Lasts exactly one cycle. `instr0`/`instr1` are stable for the whole cycle. `retired`<=`retired`+1.
  - If `pc_load`: `pc`<=`pc_target`.
  - If `instr0[31:24]`==OP_END: → ST_HLT. Otherwise → ST_FETCH0.
- PC arithmetic is modulo 2^AW: 2^AW-1 increments to 0 with no error flag. A two-word instruction whose first word sits at 2^AW-1 takes its second word from address 0.
- `instr0` and `instr1` change only at the ST_FETCH1 and ST_FETCH2 edges and are otherwise held. This includes ST_HLT, so the last instruction stays visible.
- Simultaneous events:
  - `pc_load` together with END in EXEC: the PC loads and the block still halts.
  - `start` together with `reset`: reset wins and the block stays in ST_HLT.
- Reset mid-operation from any state returns to reset values on the next edge. The in-flight instruction is discarded and not counted in `retired`.

## Timing
- One-word instruction: 3 cycles (FETCH0, FETCH1, EXEC). Two-word instruction: 4 cycles.
- Start latency: the cycle after `start` is ST_FETCH0. The first EXEC follows 2 cycles later (one-word) or 3 cycles later (two-word).
- Redirect: `pc_load` in EXEC → the next cycle is ST_FETCH0 with `imem_addr`=`pc_target`. There is no delay slot and no prefetched word is used.
- END: the cycle after END's EXEC is ST_HLT, with `halted`=1 registered in that cycle.
- All outputs except `imem_addr` are registered. `imem_addr` is a direct copy of the `pc` register.

## Test plan
- **Reset, one-word sequence.** Reset, memory [0]=0x02040005, [1]=0xF0000000, pulse `start`.
  - States run 1,2,4,1,2,4,0.
  - `instr0`=0x02040005 in the first EXEC, `instr1`=0.
  - `pc`=2 at halt, `retired`=2.
- **Two-word LIMM32.** [0]=0x20080000, [1]=0xDEADBEEF, [2]=END.
  - First EXEC has `instr0`=0x20080000 and `instr1`=0xDEADBEEF, reached 4 cycles after `start`.
  - `pc`=3 at halt.
- **Redirect.** Hold `pc_load`=1 with `pc_target`=0x0010 during the first EXEC; [0x10]=END.
  - Next cycle `imem_addr`=0x0010.
  - Halts with `pc`=0x0011 and `retired`=2.
- **PC wrap (AW=16).** `RESET_PC`=0xFFFF, [0xFFFF]=0x20.., [0x0000]=0x12345678, [1]=END.
  - `instr1`=0x12345678, then halt with `pc`=2.
- **Reset mid-fetch, ignored inputs.** Assert `reset` in ST_FETCH2.
  - Next cycle all outputs are at reset values.
  - A `start` pulse held together with `reset` keeps the block in ST_HLT.
  - A `start` pulse while running has no effect.
  - A `pc_load` pulse in ST_FETCH1 does not change `pc`.
